// File: rtl/round_timer.sv
// ============================================================================
// Module   : round_timer
// Brief    : Prescaled down-counter with pause, load and optional auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_timer #(
    parameter int CNT_W    = 4,
    parameter int INIT_VAL = 5,
    parameter int TICK_DIV = 100000000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             auto_reload_i,
    output logic [CNT_W-1:0] count_o,
    output logic             running_o,
    output logic             expired_o,
    output logic             expire_pulse_o,
    output logic             tick_o
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_VAL);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic [PRE_W-1:0] presc_q,  presc_d;
    logic             tick_q,   tick_d;
    logic             pulse_q,  pulse_d;
    logic [CNT_W-1:0] start_val;

    // A restart from DONE begins from the reload value; from IDLE it keeps
    // whatever count was loaded or left at reset.
    assign start_val = (state_q == S_DONE) ? reload_q : count_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;
        pulse_d  = 1'b0;

        if (load_i) begin
            count_d  = load_val_i;
            reload_d = load_val_i;
            state_d  = S_IDLE;
            presc_d  = '0;
        end else if (start_i && (state_q == S_IDLE || state_q == S_DONE)) begin
            count_d = start_val;
            presc_d = '0;
            if (start_val == CNT_ZERO) begin
                state_d = S_DONE;
                pulse_d = 1'b1;
            end else begin
                state_d = S_RUN;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (pause_i) begin
                        state_d = S_PAUSED;
                    end else if (presc_q == PRE_TERM) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (count_q > CNT_ONE) begin
                            count_d = count_q - CNT_ONE;
                        end else begin
                            pulse_d = 1'b1;
                            // A zero reload cannot sustain a countdown, so it expires for good.
                            if (auto_reload_i && reload_q != CNT_ZERO) begin
                                count_d = reload_q;
                            end else begin
                                count_d = CNT_ZERO;
                                state_d = S_DONE;
                            end
                        end
                    end else begin
                        presc_d = presc_q + PRE_ONE;
                    end
                end
                S_PAUSED: begin
                    if (!pause_i) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            count_q  <= CNT_INIT;
            reload_q <= CNT_INIT;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            pulse_q  <= pulse_d;
        end
    end

    assign count_o        = count_q;
    assign running_o      = (state_q == S_RUN);
    assign expired_o      = (state_q == S_DONE);
    assign expire_pulse_o = pulse_q;
    assign tick_o         = tick_q;

endmodule

`default_nettype wire
